// File: rtl/pulse_width_receive.sv
`timescale 1ns/1ps
// pulse_width_receive: recovers DATA_WIDTH-bit samples from the single-wire pulse-width audio line.
// Latency: valid_out on the 3rd clk_in rising edge after the raw falling edge of the last bit.
// Backpressure: none; each sample is presented once and data_out holds until the next sample.
//
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset; assertion is immediate, release is synchronized
//   in            serial line, asynchronous to clk_in
//   data_out      last decoded sample, held until the next one
//   valid_out     one-cycle strobe when data_out updates
//   error_out     one-cycle strobe on a malformed frame
//   err_count_out saturating count of error_out pulses (present only with RX_ERR_CNT_EN defined)
module pulse_width_receive #(
  parameter int SYNC_LOW_MIN  = 300,
  parameter int SYNC_HIGH_MIN = 500,
  parameter int SYNC_HIGH_MAX = 700,
  parameter int BIT_LOW_MAX   = 300,
  parameter int BIT_HIGH_MIN  = 100,
  parameter int BIT_THRESH    = 400,
  parameter int BIT_HIGH_MAX  = 800,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  error_out
`ifdef RX_ERR_CNT_EN
  ,
  output logic [15:0]           err_count_out
`endif
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Run counter must be able to hold one past the largest threshold before saturating.
  localparam int P_MAX = max2(max2(max2(SYNC_LOW_MIN, SYNC_HIGH_MIN), max2(SYNC_HIGH_MAX, BIT_LOW_MAX)),
                              max2(max2(BIT_HIGH_MIN, BIT_THRESH), max2(BIT_HIGH_MAX, DATA_WIDTH)));
  localparam int W  = $clog2(P_MAX + 2);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [W-1:0]  SYNC_LOW_MIN_W  = W'(SYNC_LOW_MIN);
  localparam logic [W-1:0]  SYNC_HIGH_MIN_W = W'(SYNC_HIGH_MIN);
  localparam logic [W-1:0]  SYNC_HIGH_MAX_W = W'(SYNC_HIGH_MAX);
  localparam logic [W-1:0]  BIT_LOW_MAX_W   = W'(BIT_LOW_MAX);
  localparam logic [W-1:0]  BIT_HIGH_MIN_W  = W'(BIT_HIGH_MIN);
  localparam logic [W-1:0]  BIT_THRESH_W    = W'(BIT_THRESH);
  localparam logic [W-1:0]  BIT_HIGH_MAX_W  = W'(BIT_HIGH_MAX);
  localparam logic [BW-1:0] LAST_BIT        = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SYNC_HIGH, BIT_LOW, BIT_HIGH} state_e;

  // Reset: asserts asynchronously, releases on a clock edge.
  logic rst_meta_q, rst_sync_q, rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  // Line synchronizer plus one delayed copy for edge detection.
  logic sync1_q, s_in_q, s_d_q;
  logic lvl_edge, rise, fall;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_in_q  <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= in;
      s_in_q  <= sync1_q;
      s_d_q   <= s_in_q;
    end
  end

  assign lvl_edge = s_in_q ^ s_d_q;
  assign rise     = s_in_q & ~s_d_q;
  assign fall     = ~s_in_q & s_d_q;

  // Run counter: at an edge it holds the length of the level that just ended.
  logic [W-1:0] run_q, run_d;

  always_comb begin
    run_d = run_q;
    if (lvl_edge)    run_d = W'(1);
    else if (~&run_q) run_d = run_q + W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end

  // Frame FSM with registered outputs.
  state_e                state_q;
  logic [BW-1:0]         bit_cnt_q;
  // Only the bits received so far are kept; the final bit is merged straight into data_out.
  logic [DATA_WIDTH-2:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, error_q;
  logic                  bit_val;

  assign bit_val = (run_q >= BIT_THRESH_W);
  assign shift_d = {shift_q, bit_val};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise && run_q >= SYNC_LOW_MIN_W) state_q <= SYNC_HIGH;
        end
        SYNC_HIGH: begin
          if (fall) begin
            if (run_q >= SYNC_HIGH_MIN_W && run_q <= SYNC_HIGH_MAX_W) begin
              state_q   <= BIT_LOW;
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end
          end else if (run_q > SYNC_HIGH_MAX_W) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        BIT_LOW: begin
          if (rise) begin
            // A low run that ends exactly one past the limit is still an error,
            // and being that long it may already qualify as a sync low.
            if (run_q > BIT_LOW_MAX_W) begin
              error_q <= 1'b1;
              state_q <= (run_q >= SYNC_LOW_MIN_W) ? SYNC_HIGH : IDLE;
            end else begin
              state_q <= BIT_HIGH;
            end
          end else if (run_q > BIT_LOW_MAX_W) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        BIT_HIGH: begin
          if (fall) begin
            if (run_q < BIT_HIGH_MIN_W || run_q > BIT_HIGH_MAX_W) begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end else if (bit_cnt_q == LAST_BIT) begin
              data_q  <= shift_d;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              shift_q   <= shift_d[DATA_WIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + BW'(1);
              state_q   <= BIT_LOW;
            end
          end else if (run_q > BIT_HIGH_MAX_W) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign error_out = error_q;

`ifdef RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                      err_cnt_q <= '0;
    else if (error_q && ~&err_cnt_q) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_width_receive.sv
`timescale 1ns/1ps
module tb_pulse_width_receive;

  localparam int SYNC_LOW_MIN  = 300;
  localparam int SYNC_HIGH_MIN = 500;
  localparam int SYNC_HIGH_MAX = 700;
  localparam int BIT_LOW_MAX   = 300;
  localparam int BIT_HIGH_MIN  = 100;
  localparam int BIT_THRESH    = 400;
  localparam int BIT_HIGH_MAX  = 800;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       error_out;
`ifdef RX_ERR_CNT_EN
  logic [15:0] err_count_out;
`endif

  pulse_width_receive dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .in        (in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .error_out (error_out)
`ifdef RX_ERR_CNT_EN
    ,
    .err_count_out (err_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus as a list of (level, duration-in-cycles) runs.
  bit   run_lvl[$];
  int   run_len[$];
  // Reference model results.
  logic [7:0] exp_data[$];
  int         exp_err;
  int         err_since_rst = 0;
  // Observations.
  logic [7:0] obs_data[$];
  int         obs_lat[$];
  int         obs_err_cyc[$];
  int         rise_cyc[$];
  int         last_fall_cyc = 0;
  int         pulse_viol = 0;
  logic       prev_v = 1'b0, prev_e = 1'b0;

  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      obs_data.push_back(data_out);
      obs_lat.push_back(cyc - last_fall_cyc);
    end
    if (error_out === 1'b1) obs_err_cyc.push_back(cyc);
    if (valid_out === 1'b1 && error_out === 1'b1) pulse_viol++;
    if ((valid_out === 1'b1 && prev_v) || (error_out === 1'b1 && prev_e)) pulse_viol++;
    prev_v = (valid_out === 1'b1);
    prev_e = (error_out === 1'b1);
  end

  task automatic clear_runs();
    run_lvl.delete();
    run_len.delete();
  endtask

  task automatic add(input bit l, input int n);
    run_lvl.push_back(l);
    run_len.push_back(n);
  endtask

  // lead = idle low plus sync low; nominal sync high and bit timings.
  task automatic add_frame(input int lead, input logic [7:0] d);
    add(1'b0, lead);
    add(1'b1, 600);
    for (int b = 7; b >= 0; b--) begin
      add(1'b0, 200);
      add(1'b1, d[b] ? 600 : 200);
    end
  endtask

  function automatic int pick(input int lo, input int hi, input int wlo, input int whi);
    if ($urandom_range(11, 0) == 0) return int'($urandom_range(whi, wlo));
    return int'($urandom_range(hi, lo));
  endfunction

  // Run-level decoder: judges each complete low/high run by its length.
  task automatic run_model();
    bit         in_frame;
    int         prev_low, nb, h;
    logic [7:0] acc;
    exp_data.delete();
    exp_err  = 0;
    in_frame = 0;
    prev_low = 0;
    nb       = 0;
    acc      = '0;
    for (int i = 0; i < run_len.size(); i++) begin
      h = run_len[i];
      if (run_lvl[i] == 1'b0) begin
        prev_low = h;
        if (in_frame && h > BIT_LOW_MAX) begin
          exp_err++;
          in_frame = 0;
        end
      end else if (!in_frame) begin
        if (prev_low >= SYNC_LOW_MIN) begin
          if (h < SYNC_HIGH_MIN || h > SYNC_HIGH_MAX) exp_err++;
          else begin
            in_frame = 1;
            nb       = 0;
            acc      = '0;
          end
        end
      end else begin
        if (h < BIT_HIGH_MIN || h > BIT_HIGH_MAX) begin
          exp_err++;
          in_frame = 0;
        end else begin
          acc = {acc[6:0], (h >= BIT_THRESH) ? 1'b1 : 1'b0};
          nb++;
          if (nb == 8) begin
            exp_data.push_back(acc);
            in_frame = 0;
          end
        end
      end
    end
  endtask

  task automatic drive_runs();
    for (int i = 0; i < run_len.size(); i++) begin
      if (run_lvl[i] == 1'b1 && in == 1'b0) rise_cyc.push_back(cyc);
      if (run_lvl[i] == 1'b0 && in == 1'b1) last_fall_cyc = cyc;
      in = run_lvl[i];
      repeat (run_len[i]) @(negedge clk_in);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_lat.delete();
    obs_err_cyc.delete();
    rise_cyc.delete();
  endtask

  task automatic check_scn(input string tag);
    n_cmp++;
    assert (obs_data.size() === exp_data.size()) else begin
      n_bad++;
      $error("FAIL %s valid_count: observed %0d expected %0d", tag, obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_cmp++;
      assert (obs_data[i] === exp_data[i]) else begin
        n_bad++;
        $error("FAIL %s data[%0d]: observed %h expected %h", tag, i, obs_data[i], exp_data[i]);
      end
      n_cmp++;
      assert (obs_lat[i] === 3) else begin
        n_bad++;
        $error("FAIL %s latency[%0d]: observed %0d expected 3", tag, i, obs_lat[i]);
      end
    end
    n_cmp++;
    assert (obs_err_cyc.size() === exp_err) else begin
      n_bad++;
      $error("FAIL %s error_count: observed %0d expected %0d", tag, obs_err_cyc.size(), exp_err);
    end
`ifdef RX_ERR_CNT_EN
    err_since_rst += exp_err;
    n_cmp++;
    assert (err_count_out === 16'(err_since_rst)) else begin
      n_bad++;
      $error("FAIL %s err_count_out: observed %0d expected %0d", tag, err_count_out, err_since_rst);
    end
`endif
  endtask

  task automatic run_scn(input string tag);
    run_model();
    clear_obs();
    drive_runs();
    repeat (10) @(negedge clk_in);
    check_scn(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] got;
    int         dlt;

    // Reset state.
    rst_n_in = 1'b0;
    in       = 1'b0;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    assert (data_out === 8'h00) else begin n_bad++; $error("FAIL rst_data: observed %h expected 00", data_out); end
    n_cmp++;
    assert (valid_out === 1'b0) else begin n_bad++; $error("FAIL rst_valid: observed %b expected 0", valid_out); end
    n_cmp++;
    assert (error_out === 1'b0) else begin n_bad++; $error("FAIL rst_error: observed %b expected 0", error_out); end
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    // Nominal 0xA5 after 1000 idle + 400 sync low.
    clear_runs(); add_frame(1400, 8'hA5); add(1'b0, 500);
    run_scn("a5");

    // 0x00 then 0xFF, 7000 low between frames.
    clear_runs(); add_frame(500, 8'h00); add_frame(7000, 8'hFF); add(1'b0, 500);
    run_scn("00_ff");

    // Short sync high, then a good frame.
    clear_runs(); add(1'b0, 500); add(1'b1, 300); add_frame(500, 8'h3C); add(1'b0, 500);
    run_scn("short_sync");

    // Threshold boundary: 399 -> 0, 400 -> 1.
    clear_runs(); add(1'b0, 500); add(1'b1, 600);
    for (int b = 7; b >= 0; b--) begin
      add(1'b0, 200);
      add(1'b1, b[0] ? 399 : 400);
    end
    add(1'b0, 500);
    run_scn("thresh");
    got = (obs_data.size() > 0) ? obs_data[0] : 8'h00;
    n_cmp++;
    assert (got === 8'h55) else begin n_bad++; $error("FAIL thresh_value: observed %h expected 55", got); end

    // Sync high held far too long.
    clear_runs(); add(1'b0, 500); add(1'b1, 2000); add(1'b0, 500);
    run_scn("sync_timeout");
    dlt = (obs_err_cyc.size() > 0 && rise_cyc.size() > 0) ? obs_err_cyc[0] - rise_cyc[0] : -1;
    n_cmp++;
    assert (dlt >= 702 && dlt <= 706) else begin
      n_bad++;
      $error("FAIL sync_timeout_time: observed %0d cycles after rise expected 702..706", dlt);
    end

    // Reset after 4 bits of a frame.
    clear_obs();
    clear_runs(); add(1'b0, 500); add(1'b1, 600);
    for (int b = 0; b < 4; b++) begin
      add(1'b0, 200);
      add(1'b1, b[0] ? 200 : 600);
    end
    add(1'b0, 100);
    drive_runs();
    n_cmp++;
    assert (data_out === 8'h55) else begin n_bad++; $error("FAIL pre_reset_data: observed %h expected 55", data_out); end
    #2 rst_n_in = 1'b0;
    #1;
    n_cmp++;
    assert (data_out === 8'h00) else begin n_bad++; $error("FAIL async_reset_data: observed %h expected 00", data_out); end
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    err_since_rst = 0;
    repeat (5) @(negedge clk_in);
    n_cmp++;
    assert (obs_data.size() + obs_err_cyc.size() === 0) else begin
      n_bad++;
      $error("FAIL reset_partial_pulses: observed %0d expected 0", obs_data.size() + obs_err_cyc.size());
    end
`ifdef RX_ERR_CNT_EN
    n_cmp++;
    assert (err_count_out === 16'd0) else begin n_bad++; $error("FAIL reset_err_count: observed %0d expected 0", err_count_out); end
`endif
    clear_runs(); add_frame(500, 8'h81); add(1'b0, 500);
    run_scn("after_reset");

    // Randomized frames, occasionally malformed.
    for (int s = 0; s < 2; s++) begin
      d = 8'($urandom);
      clear_runs();
      add(1'b0, 500);
      add(1'b1, pick(550, 650, 300, 800));
      for (int b = 7; b >= 0; b--) begin
        add(1'b0, pick(150, 250, 150, 350));
        add(1'b1, d[b] ? pick(450, 750, 50, 900) : pick(150, 350, 50, 900));
      end
      add(1'b0, 500);
      run_scn("random");
    end

    n_cmp++;
    assert (pulse_viol === 0) else begin n_bad++; $error("FAIL pulse_rules: observed %0d violations expected 0", pulse_viol); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
